result_collector: RTL and testbench

Receiving end of the scaler output interface. Consumes the indexed, enable-qualified scaled-value stream (index, value, enable) and assembles CELL_AMOUNT lanes into one packed row word. Completed rows go into a two-bank ping-pong buffer and are emitted on a valid/ready stream towards the writeback/DMA side. Sits directly after the scaler, at the output of the systolic array.

---
 rtl/result_collector_if.sv | 24 ++
 rtl/result_collector.sv | 117 +++++++++++
 tb/tb_result_collector.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// Stream bundle for the result collector: scaler-side lane writes in, packed rows out.
// The master modport is the environment (scaler + writeback); the slave modport is the collector.
interface result_collector_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned CELL_AMOUNT = 4
);
  logic [INDEX_WIDTH-1:0]            in_index;
  logic [DATA_WIDTH-1:0]             in_value;
  logic                              in_enable;
  logic [CELL_AMOUNT*DATA_WIDTH-1:0] out_data;
  logic                              out_valid;
  logic                              out_ready;

  modport master (
    output in_index, in_value, in_enable, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_index, in_value, in_enable, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/result_collector.sv
// Assembles indexed scaler lanes into packed rows held in a two-bank ping-pong buffer,
// and hands completed rows downstream on a valid/ready stream in completion order.
module result_collector #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned CELL_AMOUNT = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  result_collector_if.slave   bus,
  output logic                o_overflow,
  output logic                o_index_error,
  output logic [15:0]         o_dropped_count,
  output logic [15:0]         o_rows_out
);

  localparam int unsigned RowW = CELL_AMOUNT * DATA_WIDTH;

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_state_e;

  bank_state_e            r_state [2];
  bank_state_e            w_state_d [2];
  logic [RowW-1:0]        r_data [2];
  logic [RowW-1:0]        w_data_d [2];
  logic [CELL_AMOUNT-1:0] r_map [2];
  logic [CELL_AMOUNT-1:0] w_map_d [2];
  logic                   r_wr_bank, w_wr_bank_d;
  logic                   r_rd_bank, w_rd_bank_d;
  logic                   r_overflow, w_overflow_d;
  logic                   r_index_error, w_index_error_d;
  logic [15:0]            r_dropped, w_dropped_d;
  logic [15:0]            r_rows, w_rows_d;
  logic                   w_in_range;
  logic                   w_xfer;
  logic [CELL_AMOUNT-1:0] w_map_set;

  always_comb begin
    w_state_d       = r_state;
    w_data_d        = r_data;
    w_map_d         = r_map;
    w_wr_bank_d     = r_wr_bank;
    w_rd_bank_d     = r_rd_bank;
    w_overflow_d    = r_overflow;
    w_index_error_d = r_index_error;
    w_dropped_d     = r_dropped;
    w_rows_d        = r_rows;
    w_map_set       = r_map[r_wr_bank];
    w_in_range      = bus.in_index < INDEX_WIDTH'(CELL_AMOUNT);
    w_xfer          = (r_state[r_rd_bank] == StFull) && bus.out_ready;

    if (w_xfer) begin
      w_state_d[r_rd_bank] = StEmpty;
      w_rd_bank_d          = ~r_rd_bank;
      w_rows_d             = r_rows + 16'd1;
    end

    // Full-bank test uses the registered state, so a bank being drained this cycle still drops.
    if (bus.in_enable) begin
      if (!w_in_range) begin
        w_index_error_d = 1'b1;
      end else if (r_state[r_wr_bank] == StFull) begin
        w_overflow_d = 1'b1;
        w_dropped_d  = r_dropped + 16'd1;
      end else begin
        for (int unsigned i = 0; i < CELL_AMOUNT; i++) begin
          if (bus.in_index == INDEX_WIDTH'(i)) begin
            w_data_d[r_wr_bank][i*DATA_WIDTH +: DATA_WIDTH] = bus.in_value;
            if (r_map[r_wr_bank][i]) w_index_error_d = 1'b1;
            w_map_set[i] = 1'b1;
          end
        end
        if (&w_map_set) begin
          w_state_d[r_wr_bank] = StFull;
          w_map_d[r_wr_bank]   = '0;
          w_wr_bank_d          = ~r_wr_bank;
        end else begin
          w_state_d[r_wr_bank] = StFilling;
          w_map_d[r_wr_bank]   = w_map_set;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= StEmpty;
        r_data[b]  <= '0;
        r_map[b]   <= '0;
      end
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_overflow    <= 1'b0;
      r_index_error <= 1'b0;
      r_dropped     <= '0;
      r_rows        <= '0;
    end else begin
      r_state       <= w_state_d;
      r_data        <= w_data_d;
      r_map         <= w_map_d;
      r_wr_bank     <= w_wr_bank_d;
      r_rd_bank     <= w_rd_bank_d;
      r_overflow    <= w_overflow_d;
      r_index_error <= w_index_error_d;
      r_dropped     <= w_dropped_d;
      r_rows        <= w_rows_d;
    end
  end

  assign bus.out_valid   = (r_state[r_rd_bank] == StFull);
  assign bus.out_data    = r_data[r_rd_bank];
  assign o_overflow      = r_overflow;
  assign o_index_error   = r_index_error;
  assign o_dropped_count = r_dropped;
  assign o_rows_out      = r_rows;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios plus random traffic, all checked each cycle
// against a row-queue model of the collector's observable behaviour.
module tb_result_collector;

  localparam int unsigned DW   = 8;
  localparam int unsigned IW   = 10;
  localparam int unsigned CELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        overflow, index_error;
  logic [15:0] dropped_count, rows_out;

  int total = 0;
  int bad   = 0;

  result_collector_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .CELL_AMOUNT(CELL)) bus ();

  result_collector #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .CELL_AMOUNT(CELL)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .bus             (bus),
    .o_overflow      (overflow),
    .o_index_error   (index_error),
    .o_dropped_count (dropped_count),
    .o_rows_out      (rows_out)
  );

  always #5 clk = ~clk;

  // Model: completed rows waiting downstream (at most two) plus the row being assembled.
  logic [CELL*DW-1:0] m_q[$];
  logic [DW-1:0]      m_part [CELL];
  bit   [CELL-1:0]    m_mask;
  bit                 m_ovf, m_ierr;
  logic [15:0]        m_drop, m_rows;

  task automatic model_step(bit r, bit en, int idx, logic [DW-1:0] val, bit rdy);
    int  pre;
    bit  xfer;
    logic [CELL*DW-1:0] row;
    if (r) begin
      m_q.delete();
      m_mask = '0;
      m_ovf  = 1'b0;
      m_ierr = 1'b0;
      m_drop = '0;
      m_rows = '0;
      return;
    end
    pre  = m_q.size();
    xfer = (pre > 0) && rdy;
    if (en) begin
      if (idx >= int'(CELL)) m_ierr = 1'b1;
      else if (pre == 2) begin
        m_ovf  = 1'b1;
        m_drop = m_drop + 16'd1;
      end else begin
        if (m_mask[idx]) m_ierr = 1'b1;
        m_part[idx] = val;
        m_mask[idx] = 1'b1;
        if (&m_mask) begin
          for (int i = 0; i < int'(CELL); i++) row[i*DW +: DW] = m_part[i];
          m_q.push_back(row);
          m_mask = '0;
        end
      end
    end
    if (xfer) begin
      void'(m_q.pop_front());
      m_rows = m_rows + 16'd1;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("out_data", 64'(bus.out_data), 64'(m_q[0]));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("index_error", 64'(index_error), 64'(m_ierr));
    chk("dropped_count", 64'(dropped_count), 64'(m_drop));
    chk("rows_out", 64'(rows_out), 64'(m_rows));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.in_enable, int'(bus.in_index), bus.in_value, bus.out_ready);
    #1;
    compare_all();
  endtask

  task automatic drive(bit en, int idx, logic [DW-1:0] val, bit rdy);
    bus.in_enable = en;
    bus.in_index  = idx[IW-1:0];
    bus.in_value  = val;
    bus.out_ready = rdy;
    tick();
  endtask

  initial begin
    bus.in_enable = 1'b0;
    bus.in_index  = '0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;
    m_mask = '0;
    m_ovf = 1'b0; m_ierr = 1'b0; m_drop = '0; m_rows = '0;

    // Basic row with out_ready high
    rst = 1'b1;
    drive(0, 0, 8'h00, 1);
    rst = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    drive(1, 0, 8'h0A, 1);
    drive(1, 1, 8'h14, 1);
    drive(1, 2, 8'h1E, 1);
    chk("t1_not_yet", 64'(bus.out_valid), 64'd0);
    drive(1, 3, 8'h28, 1);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'h281E140A);
    drive(0, 0, 8'h00, 1);
    chk("t1_one_cycle", 64'(bus.out_valid), 64'd0);
    chk("t1_rows", 64'(rows_out), 64'd1);

    // Backpressure: A held, B buffered, C dropped
    for (int i = 0; i < 12; i++) drive(1, i % 4, 8'(i + 1), 0);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_drop", 64'(dropped_count), 64'd4);
    chk("t2_a_held", 64'(bus.out_data), 64'h04030201);
    drive(0, 0, 8'h00, 1);
    chk("t2_b", 64'(bus.out_data), 64'h08070605);
    chk("t2_b_valid", 64'(bus.out_valid), 64'd1);
    drive(0, 0, 8'h00, 1);
    chk("t2_empty", 64'(bus.out_valid), 64'd0);
    chk("t2_rows", 64'(rows_out), 64'd3);

    // Out-of-range index
    drive(1, 5, 8'h33, 1);
    chk("t3_ierr", 64'(index_error), 64'd1);
    chk("t3_novalid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 4; i++) drive(1, i, 8'(8'h11 + i), 1);
    chk("t3_data", 64'(bus.out_data), 64'h14131211);
    drive(0, 0, 8'h00, 1);

    // Duplicate lane 0: last value wins
    drive(1, 0, 8'h07, 1);
    drive(1, 0, 8'h09, 1);
    drive(1, 1, 8'h01, 1);
    drive(1, 2, 8'h02, 1);
    drive(1, 3, 8'h03, 1);
    chk("t4_data", 64'(bus.out_data), 64'h03020109);
    drive(0, 0, 8'h00, 1);

    // Transfer of one bank and completion of the other on the same edge
    for (int i = 0; i < 4; i++) drive(1, i, 8'(8'h21 + i), 0);
    for (int i = 0; i < 3; i++) drive(1, i, 8'(8'h31 + i), 0);
    drive(1, 3, 8'h34, 1);
    chk("t5_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_data", 64'(bus.out_data), 64'h34333231);
    chk("t5_rows", 64'(rows_out), 64'd6);
    chk("t5_nodrop", 64'(dropped_count), 64'd4);
    drive(0, 0, 8'h00, 1);
    chk("t5_rows2", 64'(rows_out), 64'd7);

    // Reset in the middle of a row
    drive(1, 0, 8'hAA, 1);
    drive(1, 1, 8'hBB, 1);
    rst = 1'b1;
    drive(0, 0, 8'h00, 1);
    rst = 1'b0;
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_ierr", 64'(index_error), 64'd0);
    chk("t6_drop", 64'(dropped_count), 64'd0);
    chk("t6_rows", 64'(rows_out), 64'd0);
    for (int i = 0; i < 4; i++) drive(1, i, 8'(i + 1), 1);
    chk("t6_data", 64'(bus.out_data), 64'h04030201);
    drive(0, 0, 8'h00, 1);
    chk("t6_rows1", 64'(rows_out), 64'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 5)), 8'($urandom),
            $urandom_range(0, 1) == 1);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
